simon_host_driver: RTL and testbench

Host-side requester for the SIMON32/64 precomputed-key control core. Accepts one plaintext/key/direction job from an upstream valid/ready stream and drives the core's `newData` / `doneKey` / `doneData` / `readData` handshake. Captures the core's `cipher` output and presents it on a downstream valid/ready stream. Sits between the bus/test harness and the SIMON control core, one job in flight at a time.

---
 rtl/simon_host_driver.sv | 130 +++++++++++++
 tb/tb_simon_host_driver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_host_driver.sv
// Single-job requester for the SIMON32/64 control core. Define SIMON_HOST_TIMEOUT_EN to add the watchdog and sticky err.
// Latency is 3 cycles plus the core's doneKey->doneData time. in_ready is high only in IDLE, and out_valid holds until out_ready.
module simon_host_driver #(
  parameter int N              = 16,
  parameter int M              = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             nR,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_block,
  input  logic [M*N-1:0]   in_key,
  input  logic             in_enc_dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_block,
  output logic             out_enc_dec,
  output logic             newData,
  output logic             readData,
  output logic             enc_dec,
  output logic [2*N-1:0]   plain,
  output logic [M*N-1:0]   key,
  input  logic             doneKey,
  input  logic             doneData,
  input  logic [2*N-1:0]   cipher,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_ACK       = 3'd3,
    S_OUTPUT    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_capture;
  logic             w_timeout;
  logic [2*N-1:0]   r_plain;
  logic [M*N-1:0]   r_key;
  logic             r_enc_dec;
  logic [2*N-1:0]   r_out_block;
  logic             r_out_enc_dec;

`ifdef SIMON_HOST_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_counting;

  assign w_counting = (r_state == S_LOAD) || (r_state == S_WAIT_DATA) || (r_state == S_ACK);
  assign w_timeout  = w_counting && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (in_valid)  w_state_nxt = S_LOAD;
      S_LOAD:      if (doneKey)   w_state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (doneData)  w_state_nxt = S_ACK;
      S_ACK:       if (!doneData) w_state_nxt = S_OUTPUT;
      S_OUTPUT:    if (out_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
    // The watchdog overrides any handshake progress made on the same edge.
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_capture = (r_state == S_WAIT_DATA) && (w_state_nxt == S_ACK);

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_state       <= S_IDLE;
      r_plain       <= '0;
      r_key         <= '0;
      r_enc_dec     <= 1'b0;
      r_out_block   <= '0;
      r_out_enc_dec <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_plain   <= in_block;
        r_key     <= in_key;
        r_enc_dec <= in_enc_dec;
      end
      if (w_capture) begin
        r_out_block   <= cipher;
        r_out_enc_dec <= r_enc_dec;
      end
    end
  end

`ifdef SIMON_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_timeout) r_err <= 1'b1;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_counting)        r_cnt <= r_cnt + 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready    = (r_state == S_IDLE);
  assign newData     = (r_state == S_LOAD);
  assign readData    = (r_state == S_ACK);
  assign out_valid   = (r_state == S_OUTPUT);
  assign busy        = (r_state != S_IDLE);
  assign plain       = r_plain;
  assign key         = r_key;
  assign enc_dec     = r_enc_dec;
  assign out_block   = r_out_block;
  assign out_enc_dec = r_out_enc_dec;

endmodule

// File: tb/tb_simon_host_driver.sv
// Bench for simon_host_driver: the bench acts as the SIMON core, and a behavioural SIMON32/64 model supplies the expected results.
module tb_simon_host_driver;

  logic        clk;
  logic        nR;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_block;
  logic [63:0] in_key;
  logic        in_enc_dec;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_block;
  logic        out_enc_dec;
  logic        newData;
  logic        readData;
  logic        enc_dec;
  logic [31:0] plain;
  logic [63:0] key;
  logic        doneKey;
  logic        doneData;
  logic [31:0] cipher;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  simon_host_driver #(.N(16), .M(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .nR(nR),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_key(in_key),
    .in_enc_dec(in_enc_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_enc_dec(out_enc_dec),
    .newData(newData), .readData(readData), .enc_dec(enc_dec), .plain(plain), .key(key),
    .doneKey(doneKey), .doneData(doneData), .cipher(cipher),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] fr(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // SIMON32/64 reference: the key schedule uses z0, and there are 32 rounds.
  function automatic logic [31:0] simon(input logic [31:0] blk, input logic [63:0] k, input logic e);
    logic [15:0] rk [32];
    logic [15:0] x, y, t;
    logic [61:0] z;
    z = 62'b1111101000_1001010110_0001110011_0111110100_0100101011_0000111001_10;
    for (int i = 0; i < 4; i++) rk[i] = k[i*16 +: 16];
    for (int i = 4; i < 32; i++) begin
      t = ror(rk[i-1], 3) ^ rk[i-3];
      t = t ^ ror(t, 1);
      rk[i] = ~rk[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
    end
    x = blk[31:16];
    y = blk[15:0];
    if (e) begin
      for (int i = 0; i < 32; i++) begin
        t = x; x = y ^ fr(x) ^ rk[i]; y = t;
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        t = y; y = x ^ fr(y) ^ rk[i]; x = t;
      end
    end
    return {x, y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("nd_rd_exclusive", {63'd0, newData & readData}, 64'd0);
  endtask

  task automatic run_job(input logic [31:0] blk, input logic [63:0] k, input logic e,
                         input int kd, input int dd, input int ad, input int bp,
                         input logic both);
    logic [31:0] exp_blk;
    exp_blk    = simon(blk, k, e);
    in_valid   = 1'b1;
    in_block   = blk;
    in_key     = k;
    in_enc_dec = e;
    tick();
    in_valid   = 1'b0;
    in_block   = $urandom;
    in_key     = {$urandom, $urandom};
    in_enc_dec = ~e;
    chk("load_newData", newData, 1);
    chk("load_in_ready", in_ready, 0);
    chk("load_busy", busy, 1);
    chk("plain", plain, blk);
    chk("key", key, k);
    chk("enc_dec", enc_dec, e);
    for (int i = 0; i < kd; i++) begin
      tick();
      chk("newData_held", newData, 1);
    end
    doneKey = 1'b1;
    cipher  = $urandom;
    if (both) begin
      doneData = 1'b1;
      cipher   = exp_blk;
    end
    tick();
    doneKey = 1'b0;
    chk("newData_drop", newData, 0);
    chk("readData_early", readData, 0);
    if (!both) begin
      for (int i = 0; i < dd; i++) begin
        tick();
        chk("wait_readData", readData, 0);
        chk("wait_newData", newData, 0);
      end
      doneData = 1'b1;
      cipher   = exp_blk;
    end
    tick();
    chk("readData_rise", readData, 1);
    chk("ack_out_valid", out_valid, 0);
    cipher = $urandom;
    for (int i = 0; i < ad; i++) begin
      tick();
      chk("readData_held", readData, 1);
    end
    doneData = 1'b0;
    tick();
    chk("readData_drop", readData, 0);
    chk("out_valid", out_valid, 1);
    chk("out_block", out_block, exp_blk);
    chk("out_enc_dec", out_enc_dec, e);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_block", out_block, exp_blk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_newData", newData, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("done_out_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    chk("plain_kept", plain, blk);
    chk("key_kept", key, k);
    chk("enc_dec_kept", enc_dec, e);
  endtask

  initial begin
    logic [31:0] b;
    logic [63:0] k;
    nR = 1'b0; in_valid = 1'b0; in_block = '0; in_key = '0; in_enc_dec = 1'b0;
    out_ready = 1'b0; doneKey = 1'b0; doneData = 1'b0; cipher = '0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_newData", newData, 0);
    chk("rst_readData", readData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_plain", plain, 0);
    chk("rst_key", key, 0);
    chk("rst_enc_dec", enc_dec, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_out_enc_dec", out_enc_dec, 0);
    tick();
    nR = 1'b1;
    tick();

    // Core strobes while idle must not start anything.
    doneKey = 1'b1; doneData = 1'b1; cipher = $urandom;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_newData", newData, 0);
    chk("idle_readData", readData, 0);
    doneKey = 1'b0; doneData = 1'b0;
    tick();

    k = 64'h1918_1110_0908_0100;
    run_job(32'h6565_6877, k, 1'b1, 2, 3, 1, 0, 1'b0);
    chk("kat_enc", out_block, 32'hc69b_e9bb);
    run_job(32'hc69b_e9bb, k, 1'b0, 0, 0, 0, 2, 1'b0);
    chk("kat_dec", out_block, 32'h6565_6877);
    run_job(32'h6565_6877, k, 1'b1, 1, 0, 2, 20, 1'b0);
    run_job(32'h1234_5678, k, 1'b0, 0, 0, 0, 0, 1'b1);

    for (int n = 0; n < 8; n++) begin
      b = $urandom;
      k = {$urandom, $urandom};
      run_job(b, k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      run_job(simon(b, k, 1'b1), k, 1'b0, 1, 1, 0, 0, 1'b0);
      chk("rand_round_trip", out_block, b);
    end

    // Abandon a job in WAIT_DATA with an asynchronous reset.
    in_valid = 1'b1; in_block = 32'hdead_beef; in_key = {$urandom, $urandom}; in_enc_dec = 1'b1;
    tick();
    in_valid = 1'b0;
    doneKey = 1'b1;
    tick();
    doneKey = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1);
    nR = 1'b0;
    #1;
    chk("mid_rst_newData", newData, 0);
    chk("mid_rst_readData", readData, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_plain", plain, 0);
    tick();
    nR = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);
    run_job(32'h6565_6877, 64'h1918_1110_0908_0100, 1'b1, 0, 2, 1, 1, 1'b0);
    chk("post_rst_kat", out_block, 32'hc69b_e9bb);

    // The core never answers doneKey.
    in_valid = 1'b1; in_block = $urandom; in_key = {$urandom, $urandom}; in_enc_dec = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef SIMON_HOST_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_busy", busy, 1);
      chk("to_wait_err", err, 0);
      chk("to_wait_out_valid", out_valid, 0);
    end
    tick();
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_in_ready", in_ready, 1);
    chk("to_newData", newData, 0);
    chk("to_out_valid", out_valid, 0);
    run_job(32'h6565_6877, 64'h1918_1110_0908_0100, 1'b1, 0, 0, 0, 0, 1'b0);
    chk("to_err_sticky", err, 1);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("nowd_busy", busy, 1);
    chk("nowd_newData", newData, 1);
    chk("nowd_err", err, 0);
    chk("nowd_out_valid", out_valid, 0);
`endif
    nR = 1'b0;
    #1;
    chk("final_rst_err", err, 0);
    chk("final_rst_busy", busy, 0);
    tick();
    nR = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
